// File: rtl/keccak_byte_packer.sv
// Packs a byte stream MSB-lane-first into 32-bit words for the keccak core's input port.
// Latency: word_valid rises on the edge that accepts the completing byte or msg_end; earliest transfer is the next edge.
// Backpressure: byte_ready drops while a word or pad word waits; buffer_full holds the word stable until it transfers.
//
// Ports:
//   clk, reset (async, active-low), clear (sync abort back to idle)
//   byte_in/byte_valid/byte_last/msg_end -> byte side, accepted when byte_ready=1
//   word_out/word_valid/word_last/word_byte_num -> core side, transferred when buffer_full=0
module keccak_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        msg_end,
    output logic        byte_ready,
    input  logic        buffer_full,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        word_last,
    output logic [1:0]  word_byte_num
);

    typedef enum logic [1:0] {FILL, SEND, PAD, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] word_nxt, word_ins;
    logic        valid_nxt, last_nxt;
    logic [1:0]  bnum_nxt;
    logic        pad_after, pad_nxt;   // a full final word still owes the core an empty last block
    logic        xfer;
    logic        ends_msg;

    assign byte_ready = (state == FILL);
    assign xfer       = word_valid & ~buffer_full;
    // A byte arriving together with msg_end is treated as the final byte.
    assign ends_msg   = byte_last | msg_end;

    // Drop the incoming byte into the lane selected by the current count; lanes not yet
    // written stay zero because the word register is cleared at the start of every word.
    always_comb begin
        word_ins = word_out;
        case (cnt)
            2'd0:    word_ins[31:24] = byte_in;
            2'd1:    word_ins[23:16] = byte_in;
            2'd2:    word_ins[15:8]  = byte_in;
            default: word_ins[7:0]   = byte_in;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word_out;
        last_nxt  = word_last;
        bnum_nxt  = word_byte_num;
        pad_nxt   = pad_after;

        if (clear) begin
            state_nxt = FILL;
            cnt_nxt   = 2'd0;
            word_nxt  = 32'd0;
            last_nxt  = 1'b0;
            bnum_nxt  = 2'd0;
            pad_nxt   = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (byte_valid) begin
                        word_nxt = word_ins;
                        if (cnt == 2'd3) begin
                            // A full word is never itself the last block: the core
                            // needs a separate zero-byte block when the message ends here.
                            state_nxt = SEND;
                            cnt_nxt   = 2'd0;
                            last_nxt  = 1'b0;
                            bnum_nxt  = 2'd0;
                            pad_nxt   = ends_msg;
                        end else if (ends_msg) begin
                            state_nxt = SEND;
                            cnt_nxt   = 2'd0;
                            last_nxt  = 1'b1;
                            bnum_nxt  = cnt + 2'd1;
                        end else begin
                            cnt_nxt = cnt + 2'd1;
                        end
                    end else if (msg_end) begin
                        cnt_nxt  = 2'd0;
                        last_nxt = 1'b1;
                        if (cnt == 2'd0) begin
                            state_nxt = PAD;
                            word_nxt  = 32'd0;
                            bnum_nxt  = 2'd0;
                        end else begin
                            state_nxt = SEND;
                            bnum_nxt  = cnt;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (pad_after) begin
                            state_nxt = PAD;
                            word_nxt  = 32'd0;
                            last_nxt  = 1'b1;
                            bnum_nxt  = 2'd0;
                            pad_nxt   = 1'b0;
                        end else if (word_last) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = FILL;
                            word_nxt  = 32'd0;
                            last_nxt  = 1'b0;
                            bnum_nxt  = 2'd0;
                        end
                    end
                end
                PAD: begin
                    if (xfer) begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt = DONE;
                end
            endcase
        end

        // word_valid is its own register so the core sees a clean flop output.
        valid_nxt = (state_nxt == SEND) || (state_nxt == PAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= FILL;
            cnt           <= 2'd0;
            word_out      <= 32'd0;
            word_valid    <= 1'b0;
            word_last     <= 1'b0;
            word_byte_num <= 2'd0;
            pad_after     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            word_out      <= word_nxt;
            word_valid    <= valid_nxt;
            word_last     <= last_nxt;
            word_byte_num <= bnum_nxt;
            pad_after     <= pad_nxt;
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Testbench for keccak_byte_packer: table-driven messages, hand-written corner sequences
// and randomized messages, all checked against a word-list model built from the byte list.
module tb_keccak_byte_packer;

    logic        clk, reset, clear;
    logic [7:0]  byte_in;
    logic        byte_valid, byte_last, msg_end, byte_ready, buffer_full;
    logic [31:0] word_out;
    logic        word_valid, word_last;
    logic [1:0]  word_byte_num;

    keccak_byte_packer dut (
        .clk(clk), .reset(reset), .clear(clear),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .msg_end(msg_end), .byte_ready(byte_ready), .buffer_full(buffer_full),
        .word_out(word_out), .word_valid(word_valid), .word_last(word_last),
        .word_byte_num(word_byte_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } wrec_t;

    typedef struct {
        logic [7:0]  base;
        int          n;
        int          mode;      // 0: byte_last, 1: separate msg_end, 2: msg_end with last byte
        int          nwords;
        logic [31:0] last_w;
        logic [1:0]  last_bn;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  msg[$];
    wrec_t       got_q[$];
    wrec_t       exp_q[$];
    vec_t        tbl[8];

    function automatic wrec_t mk(input logic [31:0] w, input logic l, input logic [1:0] b);
        wrec_t r;
        r.w = w; r.last = l; r.bn = b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole groups of four bytes are plain words; the tail (possibly empty)
    // becomes the last word, zero-padded, with byte_num = tail length.
    task automatic build_expected();
        int n;
        int rem;
        logic [31:0] w;
        n = msg.size();
        rem = n % 4;
        exp_q.delete();
        for (int k = 0; k < n / 4; k++)
            exp_q.push_back(mk({msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]}, 1'b0, 2'd0));
        w = 32'd0;
        for (int j = 0; j < rem; j++)
            w[31-8*j -: 8] = msg[(n/4)*4 + j];
        exp_q.push_back(mk(w, 1'b1, 2'(rem)));
    endtask

    task automatic compare_words(input string tag);
        int m;
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic idle_inputs();
        byte_valid = 1'b0; byte_last = 1'b0; msg_end = 1'b0; byte_in = 8'h00;
    endtask

    // Drives msg[] with random gaps and backpressure, records every word transfer,
    // and returns once the block has reached DONE (bounded by a cycle budget).
    task automatic run_msg(input int mode, input int bp_pct, input int gap_pct);
        int  n, idx, endi;
        bit  done_ok;
        n = msg.size();
        idx = 0;
        endi = (mode == 1) ? n + 1 : n;
        done_ok = 1'b0;
        got_q.delete();
        for (int cyc = 0; cyc < 3000 && !done_ok; cyc++) begin
            @(negedge clk);
            buffer_full = ($urandom_range(99) < bp_pct);
            idle_inputs();
            if (idx < endi && $urandom_range(99) >= gap_pct) begin
                if (idx < n) begin
                    byte_valid = 1'b1;
                    byte_in    = msg[idx];
                    if (idx == n - 1) begin
                        byte_last = (mode == 0);
                        msg_end   = (mode == 2);
                    end
                end else begin
                    msg_end = 1'b1;
                end
            end
            #1;
            if (word_valid && !buffer_full)
                got_q.push_back(mk(word_out, word_last, word_byte_num));
            if (byte_ready && (byte_valid || msg_end))
                idx++;
            if (idx >= endi && !word_valid && !byte_ready)
                done_ok = 1'b1;
        end
        chk("msg_reached_done", 64'(done_ok), 64'd1);
        @(negedge clk);
        idle_inputs();
        buffer_full = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        idle_inputs();
        buffer_full = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1 chk("after_clear", 64'({byte_ready, word_valid}), 64'(2'b10));
    endtask

    task automatic check_stuck();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in    = 8'h77;
            #1 chk("done_stuck", 64'({byte_ready, word_valid}), 64'd0);
        end
        idle_inputs();
    endtask

    task automatic push_string(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    initial begin
        string fox;
        fox = "The quick brown fox jumps over the lazy dog";
        tbl[0] = '{8'hA1, 5, 0, 2, 32'hA5000000, 2'd1};
        tbl[1] = '{8'h10, 4, 0, 2, 32'h00000000, 2'd0};
        tbl[2] = '{8'h00, 0, 1, 1, 32'h00000000, 2'd0};
        tbl[3] = '{8'h20, 3, 1, 1, 32'h20212200, 2'd3};
        tbl[4] = '{8'h30, 6, 2, 2, 32'h34350000, 2'd2};
        tbl[5] = '{8'h40, 8, 1, 3, 32'h00000000, 2'd0};
        tbl[6] = '{8'h50, 1, 0, 1, 32'h50000000, 2'd1};
        tbl[7] = '{8'h60, 7, 2, 2, 32'h64656600, 2'd3};

        reset = 1'b1; clear = 1'b0; buffer_full = 1'b0;
        idle_inputs();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({word_out, word_valid, word_last, word_byte_num, byte_ready}),
            64'({32'd0, 1'b0, 1'b0, 2'd0, 1'b1}));
        reset = 1'b1;
        @(negedge clk);
        #1 chk("post_reset_state", 64'({word_out, word_valid, word_last, word_byte_num, byte_ready}),
            64'({32'd0, 1'b0, 1'b0, 2'd0, 1'b1}));

        // Table-driven messages
        for (int r = 0; r < 8; r++) begin
            msg.delete();
            for (int i = 0; i < tbl[r].n; i++) msg.push_back(8'(tbl[r].base + 8'(i)));
            run_msg(tbl[r].mode, 30, 20);
            build_expected();
            compare_words($sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d_count", r), 64'(got_q.size()), 64'(tbl[r].nwords));
            if (got_q.size() > 0)
                chk($sformatf("tbl%0d_last", r), 64'(got_q[got_q.size()-1]),
                    64'(mk(tbl[r].last_w, 1'b1, tbl[r].last_bn)));
            check_stuck();
            do_clear();
        end

        // Pangram, 43 bytes: ends on a 3-byte partial word
        push_string(fox);
        run_msg(0, 25, 10);
        build_expected();
        compare_words("fox43");
        chk("fox43_count", 64'(got_q.size()), 64'd11);
        if (got_q.size() == 11) begin
            chk("fox43_first", 64'(got_q[0]), 64'(mk(32'h54686520, 1'b0, 2'd0)));
            chk("fox43_last", 64'(got_q[10]), 64'(mk(32'h646F6700, 1'b1, 2'd3)));
        end
        do_clear();

        // Pangram plus '.', 44 bytes: full final word then a pad word
        push_string({fox, "."});
        run_msg(0, 25, 10);
        build_expected();
        compare_words("fox44");
        chk("fox44_count", 64'(got_q.size()), 64'd12);
        if (got_q.size() == 12) begin
            chk("fox44_w10", 64'(got_q[10]), 64'(mk(32'h646F672E, 1'b0, 2'd0)));
            chk("fox44_pad", 64'(got_q[11]), 64'(mk(32'h00000000, 1'b1, 2'd0)));
        end
        do_clear();

        // Backpressure: word held for 5 cycles, then exactly one transfer
        @(negedge clk);
        buffer_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'(i + 1);
            @(negedge clk);
        end
        byte_in = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_hold", 64'({word_out, word_valid, word_last, word_byte_num, byte_ready}),
                64'({32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0}));
            @(negedge clk);
        end
        buffer_full = 1'b0;
        idle_inputs();
        #1 chk("bp_release_valid", 64'(word_valid), 64'd1);
        @(negedge clk);
        #1 chk("bp_one_transfer", 64'({word_valid, byte_ready, word_out}), 64'({1'b0, 1'b1, 32'd0}));
        do_clear();

        // Clear mid-word discards the partial bytes
        @(negedge clk);
        byte_valid = 1'b1; byte_in = 8'hAA;
        @(negedge clk);
        byte_in = 8'hBB;
        @(negedge clk);
        idle_inputs();
        do_clear();
        msg = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_msg(1, 20, 0);
        build_expected();
        compare_words("clr");
        if (got_q.size() > 0)
            chk("clr_first", 64'(got_q[0]), 64'(mk(32'h11223344, 1'b0, 2'd0)));
        do_clear();

        // Reset mid-message discards partial state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1; byte_in = 8'(8'hC0 + 8'(i));
            @(negedge clk);
        end
        idle_inputs();
        reset = 1'b0;
        #1 chk("midrst_state", 64'({word_out, word_valid, word_last, word_byte_num, byte_ready}),
            64'({32'd0, 1'b0, 1'b0, 2'd0, 1'b1}));
        @(negedge clk);
        reset = 1'b1;
        msg = '{8'h5A};
        run_msg(0, 0, 0);
        build_expected();
        compare_words("midrst");
        do_clear();

        // Randomized messages
        for (int t = 0; t < 25; t++) begin
            int n, mode;
            n = $urandom_range(20);
            mode = $urandom_range(2);
            if (n == 0) mode = 1;
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            run_msg(mode, $urandom_range(60), $urandom_range(40));
            build_expected();
            compare_words($sformatf("rnd%0d", t));
            do_clear();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 clear  input  1  synchronous message abort; returns the block to idle.
REQ-005 byte_in  input  8  message byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_last  input  1  with byte_valid, byte_in is the final message byte.
REQ-008 msg_end  input  1  ends the message after the bytes already accepted, with no new byte.
REQ-009 byte_ready  output  1  the block accepts a byte or msg_end this cycle.
REQ-010 buffer_full  input  1  from the keccak core; 1 = the core refuses a word this cycle.
REQ-011 word_out  output  32  packed word to the core's in port.
REQ-012 word_valid  output  1  drives the core's in_ready.
REQ-013 word_last  output  1  drives the core's is_last.
REQ-014 word_byte_num  output  2  drives the core's byte_num.

Function
REQ-015 Byte handshake: a byte is accepted on a rising edge where byte_valid=1 and byte_ready=1; msg_end is accepted on a rising edge where msg_end=1 and byte_ready=1.
REQ-016 Word handshake: a word transfers on a rising edge where word_valid=1 and buffer_full=0.
REQ-017 Packing order: the first byte of a word goes to word_out[31:24], then [23:16], then [15:8], then [7:0].
REQ-018 Unused low-order byte lanes of a final word SHALL be 0.
REQ-019 States: FILL, SEND, PAD, DONE; byte_ready=1 only in FILL.
REQ-020 FILL keeps a byte count of 0..3 and a shift register.
REQ-021 FILL, 4th byte accepted with byte_last=0 -> SEND with word_last=0 and word_byte_num=0.
REQ-022 FILL, 4th byte accepted with byte_last=1 -> SEND with word_last=0; the transfer is then followed by PAD.
REQ-023 FILL, byte with byte_last=1 accepted at count k<3 -> SEND with word_last=1 and word_byte_num=k+1.
REQ-024 FILL, msg_end accepted at count 0 -> PAD.
REQ-025 FILL, msg_end accepted at count k in 1..3 -> SEND with the partial word, word_last=1 and word_byte_num=k.
REQ-026 byte_valid and msg_end in the same cycle -> the byte is processed as if byte_last=1; msg_end is consumed.
REQ-027 SEND: word_valid=1, and word_out, word_last and word_byte_num are held stable until the transfer.
REQ-028 SEND on transfer: next state is PAD if flagged by REQ-022, DONE if word_last=1, otherwise FILL with count 0.
REQ-029 PAD: word_out=0, word_byte_num=0, word_last=1 and word_valid=1; on transfer -> DONE.
REQ-030 DONE: word_valid=0 and byte_ready=0; the block stays in DONE until clear.
REQ-031 Latency: word_valid rises on the edge that accepts the completing byte or msg_end; the earliest transfer is the following edge.
REQ-032 Throughput: byte_ready=0 while in SEND or PAD; no bytes are accepted during backpressure.
REQ-033 clear=1 in any state -> next state FILL, count 0, word_valid=0; any partial word is discarded.
REQ-034 clear has priority over a simultaneous byte, msg_end or word transfer.
REQ-035 word_valid, word_last and word_byte_num SHALL be driven directly from registers, not combinationally from inputs.

Reset
REQ-036 While reset=0, and immediately after its release, the state SHALL be FILL with count=0, word_out=0, word_valid=0, word_last=0, word_byte_num=0 and byte_ready=1.
REQ-037 Reset asserted mid-message SHALL discard all partial state with no further word output.

Verification
REQ-038 Bytes A1,A2,A3,A4,A5 with byte_last on A5, buffer_full=0 -> the bench sees A1A2A3A4 (last=0), then A5000000 (last=1, byte_num=1), then DONE.
REQ-039 The 43-byte "The quick brown fox jumps over the lazy dog" -> the bench sees 10 words with last=0, then 0x646F6700 (last=1, byte_num=3); the core digest is d135bb84...f609.
REQ-040 The same string plus "." (44 bytes, byte_last on ".") -> the bench sees 11 words with last=0, then a PAD word 0x00000000 (last=1, byte_num=0); the core digest is ab7192d2...d760.
REQ-041 msg_end alone after reset -> the bench sees a single word 0x00000000 (last=1, byte_num=0); later bytes see byte_ready=0 until clear.
REQ-042 buffer_full=1 for 5 cycles during SEND -> word_out, word_last and word_byte_num stay constant, byte_ready=0, and exactly one transfer occurs after buffer_full falls.
REQ-043 clear after 2 bytes, then 4 new bytes 11,22,33,44 -> the bench sees only 11223344 (last=0); the discarded bytes never appear.
